// File: rtl/cpu_memory_interface_if.sv
`default_nettype none
// ============================================================================
// cpu_memory_interface_if : data-bus signals between the CPU and memory.
// Revision 1.0
// ============================================================================
interface cpu_memory_interface_if;
    logic        dcpu_request;
    logic        dcpu_write;
    logic [31:0] dcpu_address;
    logic [3:0]  dcpu_wmask;
    logic [31:0] dcpu_wdata;
    logic        dcpu_ack;
    logic [31:0] dcpu_rdata;

    modport master (
        output dcpu_request,
        output dcpu_write,
        output dcpu_address,
        output dcpu_wmask,
        output dcpu_wdata,
        input  dcpu_ack,
        input  dcpu_rdata
    );

    modport slave (
        input  dcpu_request,
        input  dcpu_write,
        input  dcpu_address,
        input  dcpu_wmask,
        input  dcpu_wdata,
        output dcpu_ack,
        output dcpu_rdata
    );
endinterface
`default_nettype wire

// File: rtl/cpu_memory_interface.sv
`default_nettype none
// ============================================================================
// cpu_memory_interface : data-side load/store port, one outstanding access.
// Revision 1.0
// ============================================================================
module cpu_memory_interface #(
    parameter int TIMEOUT_CYCLES = 0
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [5:0]             p3_op_i,
    input  logic [31:0]            p3_addr_i,
    input  logic [31:0]            p3_wdata_i,
    input  logic                   stall_i,
    cpu_memory_interface_if.master dbus,
    output logic                   p3_misaligned_o,
    output logic                   p4_read_pending_o,
    output logic                   p4_write_pending_o,
    output logic [31:0]            p4_mem_rdata_o,
    output logic                   p4_bus_error_o
);

    localparam logic [5:0] OP_LD   = 6'h01;
    localparam logic [5:0] OP_LDB  = 6'h10;
    localparam logic [5:0] OP_LDH  = 6'h11;
    localparam logic [5:0] OP_LDW  = 6'h12;
    localparam logic [5:0] OP_LDBU = 6'h13;
    localparam logic [5:0] OP_LDHU = 6'h14;
    localparam logic [5:0] OP_STB  = 6'h18;
    localparam logic [5:0] OP_STH  = 6'h19;
    localparam logic [5:0] OP_STW  = 6'h1A;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;

    localparam bit TO_EN = (TIMEOUT_CYCLES > 0);
    localparam int CNT_W = TO_EN ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] TO_LAST = TO_EN ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    state_t           state_q;
    logic             is_write_q;
    logic [1:0]       size_q;
    logic             sext_q;
    logic [1:0]       addr_lo_q;
    logic [CNT_W-1:0] cnt_q;
    logic [31:0]      rdata_q;
    logic             bus_error_q;

    logic        is_load;
    logic        is_store;
    logic [1:0]  size;
    logic        sext;
    logic        request;
    logic        waiting;
    logic        timeout_hit;
    logic [7:0]  lane_b;
    logic [15:0] lane_h;
    logic [31:0] load_fmt_d;

    always_comb begin
        is_load  = 1'b0;
        is_store = 1'b0;
        size     = SZ_W;
        sext     = 1'b0;
        case (p3_op_i)
            OP_LDB:  begin is_load  = 1'b1; size = SZ_B; sext = 1'b1; end
            OP_LDH:  begin is_load  = 1'b1; size = SZ_H; sext = 1'b1; end
            OP_LDW:  begin is_load  = 1'b1; size = SZ_W; end
            OP_LDBU: begin is_load  = 1'b1; size = SZ_B; end
            OP_LDHU: begin is_load  = 1'b1; size = SZ_H; end
            OP_STB:  begin is_store = 1'b1; size = SZ_B; end
            OP_STH:  begin is_store = 1'b1; size = SZ_H; end
            OP_STW:  begin is_store = 1'b1; size = SZ_W; end
            OP_LD:   ;
            default: ;
        endcase
    end

    assign p3_misaligned_o = (is_load | is_store) &
                             (((size == SZ_H) & p3_addr_i[0]) |
                              ((size == SZ_W) & (|p3_addr_i[1:0])));

    assign request           = (is_load | is_store) & ~p3_misaligned_o & ~stall_i & reset;
    assign dbus.dcpu_request = request;
    assign dbus.dcpu_write   = is_store;
    assign dbus.dcpu_address = {p3_addr_i[31:2], 2'b00};

    // Store data is replicated across every lane so the bus only needs the mask.
    always_comb begin
        dbus.dcpu_wmask = 4'b0000;
        dbus.dcpu_wdata = p3_wdata_i;
        if (is_store) begin
            case (size)
                SZ_B: begin
                    dbus.dcpu_wmask = 4'b0001 << p3_addr_i[1:0];
                    dbus.dcpu_wdata = {4{p3_wdata_i[7:0]}};
                end
                SZ_H: begin
                    dbus.dcpu_wmask = p3_addr_i[1] ? 4'b1100 : 4'b0011;
                    dbus.dcpu_wdata = {2{p3_wdata_i[15:0]}};
                end
                default: dbus.dcpu_wmask = 4'b1111;
            endcase
        end
    end

    always_comb begin
        case (addr_lo_q)
            2'd0:    lane_b = dbus.dcpu_rdata[7:0];
            2'd1:    lane_b = dbus.dcpu_rdata[15:8];
            2'd2:    lane_b = dbus.dcpu_rdata[23:16];
            default: lane_b = dbus.dcpu_rdata[31:24];
        endcase
        lane_h = addr_lo_q[1] ? dbus.dcpu_rdata[31:16] : dbus.dcpu_rdata[15:0];
        case (size_q)
            SZ_B:    load_fmt_d = {{24{sext_q & lane_b[7]}}, lane_b};
            SZ_H:    load_fmt_d = {{16{sext_q & lane_h[15]}}, lane_h};
            default: load_fmt_d = dbus.dcpu_rdata;
        endcase
    end

    assign waiting     = (state_q == S_WAIT);
    assign timeout_hit = TO_EN && (cnt_q == TO_LAST);

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            is_write_q  <= 1'b0;
            size_q      <= SZ_W;
            sext_q      <= 1'b0;
            addr_lo_q   <= 2'b00;
            cnt_q       <= '0;
            rdata_q     <= 32'h0;
            bus_error_q <= 1'b0;
        end else begin
            // An advancing instruction starts with a clean error flag.
            if (!stall_i) begin
                bus_error_q <= 1'b0;
            end
            case (state_q)
                S_IDLE: begin
                    if (request) begin
                        state_q    <= S_WAIT;
                        is_write_q <= is_store;
                        size_q     <= size;
                        sext_q     <= sext;
                        addr_lo_q  <= p3_addr_i[1:0];
                        cnt_q      <= '0;
                    end
                end
                S_WAIT: begin
                    if (dbus.dcpu_ack) begin
                        state_q <= S_IDLE;
                        if (!is_write_q) begin
                            rdata_q <= load_fmt_d;
                        end
                    end else if (timeout_hit) begin
                        state_q     <= S_IDLE;
                        bus_error_q <= 1'b1;
                        rdata_q     <= 32'h0;
                    end else if (TO_EN) begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign p4_read_pending_o  = waiting & ~is_write_q & ~dbus.dcpu_ack;
    assign p4_write_pending_o = waiting &  is_write_q & ~dbus.dcpu_ack;
    assign p4_mem_rdata_o     = (waiting & dbus.dcpu_ack) ? load_fmt_d : rdata_q;
    assign p4_bus_error_o     = bus_error_q;

endmodule
`default_nettype wire
